// File: rtl/anita4_trig_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : anita4_trig_pkg
//  Brief   : Shared constants for the ANITA-4 trigger scaler path: scaler
//            index map and the read-handshake state encoding.
//  Revision: 1.0
// ============================================================================
package anita4_trig_pkg;

    localparam int NUM_L1_SCALERS = 6;
    localparam int NUM_L2_SCALERS = 2;

    // Scaler slot order follows the L1 flag order {top,mid,bot} for phi0,
    // then phi1, followed by the two L2 phi outputs.
    localparam int SC_TOP0 = 0;
    localparam int SC_MID0 = 1;
    localparam int SC_BOT0 = 2;
    localparam int SC_TOP1 = 3;
    localparam int SC_MID1 = 4;
    localparam int SC_BOT1 = 5;
    localparam int SC_L2_0 = 6;
    localparam int SC_L2_1 = 7;

    typedef enum logic [1:0] {
        RD_IDLE     = 2'd0,
        RD_ACK      = 2'd1,
        RD_WAIT_LOW = 2'd2
    } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/anita4_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module  : anita4_sat_counter
//  Brief   : Saturating event counter with a sticky saturation flag. A
//            clear/load restarts the count at load_val_i (0 or 1 event).
//  Revision: 1.0
// ============================================================================
module anita4_sat_counter
    import anita4_trig_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 mclk_i,
    input  logic                 rst_i,
    input  logic                 inc_i,
    input  logic                 clr_load_i,
    input  logic                 load_val_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 sat_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 sat_q, sat_d;

    // Next count: reload wins over increment; the count holds at all-ones and
    // the flag latches as soon as all-ones is reached.
    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clr_load_i) begin
            count_d = {{(CNT_WIDTH-1){1'b0}}, load_val_i};
            sat_d   = 1'b0;
        end else if (inc_i && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
        if (count_d == CNT_MAX) begin
            sat_d = 1'b1;
        end
    end

    // Count and sticky flag registers.
    always_ff @(posedge mclk_i) begin
        if (rst_i) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count_o = count_q;
    assign sat_o   = sat_q;

endmodule
`default_nettype wire

// File: rtl/anita4_trig_scaler_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : anita4_trig_scaler_ctrl
//  Brief   : Gated rate counters for the L1/L2 trigger scalers. A down-counter
//            defines the gate; on its last cycle (the dump cycle) the live
//            counts move into a shadow bank, which is read out over a
//            level-request / one-cycle-ack handshake.
//            The shadow takes the live count as it stands entering the dump
//            cycle; a pulse arriving on the dump cycle seeds the next gate,
//            so every event lands in exactly one gate.
//  Revision: 1.0
// ============================================================================
module anita4_trig_scaler_ctrl
    import anita4_trig_pkg::*;
#(
    parameter int                      NUM_SCALERS  = 8,
    parameter int                      CNT_WIDTH    = 16,
    parameter int                      PERIOD_WIDTH = 24,
    parameter logic [PERIOD_WIDTH-1:0] DEF_PERIOD   = 24'd1000
) (
    input  logic                    mclk_i,
    input  logic                    rst_i,
    input  logic [NUM_SCALERS-1:0]  scaler_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    input  logic                    period_load_i,
    input  logic                    rd_req_i,
    input  logic [2:0]              rd_addr_i,
    output logic                    rd_ack_o,
    output logic [CNT_WIDTH-1:0]    rd_data_o,
    output logic                    rd_sat_o,
    output logic                    update_o,
    output logic [7:0]              gate_seq_o
);

    localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};

    logic [PERIOD_WIDTH-1:0] period_q;
    logic [PERIOD_WIDTH-1:0] cnt_q;
    logic [PERIOD_WIDTH-1:0] period_load_d;
    logic                    dump_d;
    logic                    live_clr_d;
    logic                    update_q;
    logic [7:0]              gate_seq_q;

    logic [NUM_SCALERS-1:0][CNT_WIDTH-1:0] live_cnt;
    logic [NUM_SCALERS-1:0]                live_sat;
    logic [NUM_SCALERS-1:0][CNT_WIDTH-1:0] shadow_q;
    logic [NUM_SCALERS-1:0]                shadow_sat_q;

    rd_state_e               rd_state_q;
    logic                    rd_ack_q;
    logic [CNT_WIDTH-1:0]    rd_data_q;
    logic                    rd_sat_q;
    logic                    rd_addr_ok;
    logic [CNT_WIDTH-1:0]    rd_data_d;
    logic                    rd_sat_d;

    // A zero period would never terminate the down-count, so it becomes 1.
    assign period_load_d = (period_i == '0) ? PERIOD_ONE : period_i;
    // A period load restarts the gate and suppresses the dump it coincides with.
    assign dump_d        = (cnt_q == '0) && !period_load_i;
    assign live_clr_d    = dump_d || period_load_i;

    // Gate down-counter, refresh pulse and refresh sequence number.
    always_ff @(posedge mclk_i) begin
        if (rst_i) begin
            period_q   <= DEF_PERIOD;
            cnt_q      <= DEF_PERIOD - PERIOD_ONE;
            update_q   <= 1'b0;
            gate_seq_q <= '0;
        end else begin
            update_q <= dump_d;
            if (period_load_i) begin
                period_q <= period_load_d;
                cnt_q    <= period_load_d - PERIOD_ONE;
            end else if (dump_d) begin
                cnt_q      <= period_q - PERIOD_ONE;
                gate_seq_q <= gate_seq_q + 8'd1;
            end else begin
                cnt_q <= cnt_q - PERIOD_ONE;
            end
        end
    end

    // One live counter per scaler; pulses on a period-load cycle are dropped.
    for (genvar gi = 0; gi < NUM_SCALERS; gi++) begin : g_scaler
        anita4_sat_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .mclk_i     (mclk_i),
            .rst_i      (rst_i),
            .inc_i      (scaler_i[gi]),
            .clr_load_i (live_clr_d),
            .load_val_i (scaler_i[gi] && !period_load_i),
            .count_o    (live_cnt[gi]),
            .sat_o      (live_sat[gi])
        );
    end

    // Shadow bank captures the finished gate on the dump edge.
    always_ff @(posedge mclk_i) begin
        if (rst_i) begin
            shadow_q     <= '0;
            shadow_sat_q <= '0;
        end else if (dump_d) begin
            shadow_q     <= live_cnt;
            shadow_sat_q <= live_sat;
        end
    end

    // Addresses beyond the populated slots read back as zero.
    if (NUM_SCALERS >= 8) begin : g_addr_full
        assign rd_addr_ok = 1'b1;
    end else begin : g_addr_part
        assign rd_addr_ok = (rd_addr_i < 3'(NUM_SCALERS));
    end

    assign rd_data_d = rd_addr_ok ? shadow_q[rd_addr_i]     : '0;
    assign rd_sat_d  = rd_addr_ok ? shadow_sat_q[rd_addr_i] : 1'b0;

    // Read handshake: one ack per request level, data zeroed outside the ack.
    always_ff @(posedge mclk_i) begin
        if (rst_i) begin
            rd_state_q <= RD_IDLE;
            rd_ack_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_sat_q   <= 1'b0;
        end else begin
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
            rd_sat_q  <= 1'b0;
            case (rd_state_q)
                RD_IDLE: begin
                    if (rd_req_i) begin
                        rd_state_q <= RD_ACK;
                        rd_ack_q   <= 1'b1;
                        rd_data_q  <= rd_data_d;
                        rd_sat_q   <= rd_sat_d;
                    end
                end
                RD_ACK: begin
                    rd_state_q <= RD_WAIT_LOW;
                end
                RD_WAIT_LOW: begin
                    if (!rd_req_i) begin
                        rd_state_q <= RD_IDLE;
                    end
                end
                default: begin
                    rd_state_q <= RD_IDLE;
                end
            endcase
        end
    end

    assign rd_ack_o   = rd_ack_q;
    assign rd_data_o  = rd_data_q;
    assign rd_sat_o   = rd_sat_q;
    assign update_o   = update_q;
    assign gate_seq_o = gate_seq_q;

endmodule
`default_nettype wire
